// File: rtl/uart_rx_frame_ctrl_pkg.sv
// uart_rx_frame_ctrl_pkg: shared frame-controller state encodings, defaults and length check.
package uart_rx_frame_ctrl_pkg;
   typedef enum logic [2:0] {ST_HUNT, ST_LEN, ST_PAYLOAD, ST_CHK, ST_HOLD} state_e;
   localparam logic [7:0] DEF_SYNC_BYTE = 8'h7A;
   localparam int DEF_MAX_LEN = 16;
   localparam int DEF_TIMEOUT_CLKS = 2000;
   function automatic logic len_ok(input logic [7:0] len, input int max_len);
      return len != 8'd0 && int'(len) <= max_len;
   endfunction
endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// uart_rx_frame_ctrl_if: receiver byte stream in, validated frame and error strobes out.
interface uart_rx_frame_ctrl_if #(parameter int MAX_LEN = 16);
   localparam int LEN_W = $clog2(MAX_LEN + 1);
   localparam int ADDR_W = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
   logic              i_rx_valid;
   logic [7:0]        i_rx_byte;
   logic              o_frame_valid;
   logic [LEN_W-1:0]  o_frame_len;
   logic              i_frame_ack;
   logic [ADDR_W-1:0] i_rd_addr;
   logic [7:0]        o_rd_data;
   logic              o_err_chksum;
   logic              o_err_len;
   logic              o_err_timeout;
   logic              o_overrun;
   modport slave (
      input  i_rx_valid, i_rx_byte, i_frame_ack, i_rd_addr,
      output o_frame_valid, o_frame_len, o_rd_data, o_err_chksum, o_err_len, o_err_timeout, o_overrun
   );
   modport master (
      output i_rx_valid, i_rx_byte, i_frame_ack, i_rd_addr,
      input  o_frame_valid, o_frame_len, o_rd_data, o_err_chksum, o_err_len, o_err_timeout, o_overrun
   );
endinterface

// File: rtl/uart_frame_buf.sv
// uart_frame_buf: MAX_LEN x 8 payload store with one write port and a registered read port
// that returns zero at or beyond the held frame length.
module uart_frame_buf #(
   parameter int MAX_LEN = 16,
   parameter int LEN_W = $clog2(MAX_LEN + 1),
   parameter int ADDR_W = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [7:0]        i_wdata,
   input  logic [ADDR_W-1:0] i_rd_addr,
   input  logic [LEN_W-1:0]  i_rd_len,
   output logic [7:0]        o_rd_data
);
   logic [7:0] mem_q [MAX_LEN];
   logic [7:0] rd_data_d, rd_data_q;
   always_ff @(posedge i_clk) if (i_we) mem_q[i_waddr] <= i_wdata;
   // i_rd_len is zero whenever no frame is held, so this also hides stale contents
   always_comb rd_data_d = (LEN_W'(i_rd_addr) < i_rd_len) ? mem_q[i_rd_addr] : 8'h00;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) rd_data_q <= 8'h00;
      else rd_data_q <= rd_data_d;
   assign o_rd_data = rd_data_q;
endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: hunts for SYNC, collects LEN/payload/CHK, holds validated frames
// for a valid/ack consumer and raises one-cycle error strobes.
module uart_rx_frame_ctrl
   import uart_rx_frame_ctrl_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
   parameter int MAX_LEN = DEF_MAX_LEN,
   parameter int TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
   input logic i_clk,
   input logic i_rst_n,
   uart_rx_frame_ctrl_if.slave bus
);
   localparam int LEN_W = $clog2(MAX_LEN + 1);
   localparam int ADDR_W = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
   localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
   state_e state_d, state_q;
   logic [7:0] acc_d, acc_q, sum;
   logic [LEN_W-1:0] len_d, len_q, idx_d, idx_q, flen_d, flen_q;
   logic [TMO_W-1:0] tmo_d, tmo_q;
   logic valid_d, valid_q, err_len_d, err_len_q, err_chk_d, err_chk_q;
   logic err_tmo_d, err_tmo_q, ovr_d, ovr_q, in_frame, tmo_hit, we;
   always_comb begin
      in_frame = state_q inside {ST_LEN, ST_PAYLOAD, ST_CHK};
      sum = acc_q + bus.i_rx_byte;
      // a byte landing on the expiry cycle wins over the timeout
      tmo_hit = in_frame && !bus.i_rx_valid && tmo_q == TMO_W'(TIMEOUT_CLKS);
      state_d = state_q;
      acc_d = acc_q;
      len_d = len_q;
      idx_d = idx_q;
      valid_d = valid_q;
      flen_d = flen_q;
      tmo_d = (in_frame && !bus.i_rx_valid) ? tmo_q + TMO_W'(1) : '0;
      err_len_d = 1'b0;
      err_chk_d = 1'b0;
      err_tmo_d = tmo_hit;
      ovr_d = state_q == ST_HOLD && bus.i_rx_valid;
      we = 1'b0;
      if (tmo_hit) begin
         state_d = ST_HUNT;
         tmo_d = '0;
      end else if (bus.i_rx_valid) begin
         case (state_q)
            ST_HUNT: begin
               acc_d = bus.i_rx_byte == SYNC_BYTE ? 8'h00 : acc_q;
               state_d = bus.i_rx_byte == SYNC_BYTE ? ST_LEN : ST_HUNT;
            end
            ST_LEN: begin
               err_len_d = !len_ok(bus.i_rx_byte, MAX_LEN);
               state_d = err_len_d ? ST_HUNT : ST_PAYLOAD;
               len_d = bus.i_rx_byte[LEN_W-1:0];
               acc_d = bus.i_rx_byte;
               idx_d = '0;
            end
            ST_PAYLOAD: begin
               we = 1'b1;
               acc_d = sum;
               idx_d = idx_q + LEN_W'(1);
               state_d = idx_d == len_q ? ST_CHK : ST_PAYLOAD;
            end
            ST_CHK: begin
               valid_d = sum == 8'h00;
               flen_d = sum == 8'h00 ? len_q : '0;
               err_chk_d = sum != 8'h00;
               state_d = sum == 8'h00 ? ST_HOLD : ST_HUNT;
            end
            default: ;
         endcase
      end
      if (state_q == ST_HOLD && bus.i_frame_ack) begin
         valid_d = 1'b0;
         flen_d = '0;
         state_d = ST_HUNT;
      end
   end
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         state_q <= ST_HUNT;
         acc_q <= '0;
         len_q <= '0;
         idx_q <= '0;
         flen_q <= '0;
         tmo_q <= '0;
         valid_q <= 1'b0;
         err_len_q <= 1'b0;
         err_chk_q <= 1'b0;
         err_tmo_q <= 1'b0;
         ovr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q <= acc_d;
         len_q <= len_d;
         idx_q <= idx_d;
         flen_q <= flen_d;
         tmo_q <= tmo_d;
         valid_q <= valid_d;
         err_len_q <= err_len_d;
         err_chk_q <= err_chk_d;
         err_tmo_q <= err_tmo_d;
         ovr_q <= ovr_d;
      end
   uart_frame_buf #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .ADDR_W(ADDR_W)) u_buf (
      .i_clk(i_clk),
      .i_rst_n(i_rst_n),
      .i_we(we),
      .i_waddr(idx_q[ADDR_W-1:0]),
      .i_wdata(bus.i_rx_byte),
      .i_rd_addr(bus.i_rd_addr),
      .i_rd_len(flen_q),
      .o_rd_data(bus.o_rd_data)
   );
   assign bus.o_frame_valid = valid_q;
   assign bus.o_frame_len = flen_q;
   assign bus.o_err_chksum = err_chk_q;
   assign bus.o_err_len = err_len_q;
   assign bus.o_err_timeout = err_tmo_q;
   assign bus.o_overrun = ovr_q;
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed frame scenarios against hand-computed frame, payload and strobe values.
module tb_uart_rx_frame_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int total = 0;
   int bad = 0;
   int n_chk = 0, n_len = 0, n_tmo = 0, n_ovr = 0;
   always #5 clk = ~clk;
   uart_rx_frame_ctrl_if #(.MAX_LEN(16)) bus ();
   uart_rx_frame_ctrl #(.SYNC_BYTE(8'h7A), .MAX_LEN(16), .TIMEOUT_CLKS(2000)) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .bus(bus.slave)
   );
   always @(posedge clk) begin
      if (bus.o_err_chksum) n_chk++;
      if (bus.o_err_len) n_len++;
      if (bus.o_err_timeout) n_tmo++;
      if (bus.o_overrun) n_ovr++;
   end
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic send(input logic [7:0] b);
      bus.i_rx_valid = 1'b1;
      bus.i_rx_byte = b;
      @(negedge clk);
      bus.i_rx_valid = 1'b0;
      bus.i_rx_byte = 8'h00;
   endtask
   task automatic send_gap(input logic [7:0] b);
      send(b);
      idle(3);
   endtask
   task automatic do_ack();
      bus.i_frame_ack = 1'b1;
      @(negedge clk);
      bus.i_frame_ack = 1'b0;
   endtask
   task automatic read(input logic [3:0] a);
      bus.i_rd_addr = a;
      @(negedge clk);
   endtask
   task automatic test_reset();
      bus.i_rx_valid = 1'b0; bus.i_rx_byte = 8'h00; bus.i_frame_ack = 1'b0; bus.i_rd_addr = 4'h0;
      rst_n = 1'b0;
      idle(3);
      total++; if (bus.o_frame_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.o_frame_valid); end
      total++; if (bus.o_frame_len !== 5'd0) begin bad++; $display("FAIL reset_len got=%0d exp=0", bus.o_frame_len); end
      total++; if (bus.o_rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data got=%h exp=00", bus.o_rd_data); end
      total++; if ({bus.o_err_chksum, bus.o_err_len, bus.o_err_timeout, bus.o_overrun} !== 4'b0000) begin
         bad++; $display("FAIL reset_strobes got=%b exp=0000", {bus.o_err_chksum, bus.o_err_len, bus.o_err_timeout, bus.o_overrun}); end
      rst_n = 1'b1;
      idle(2);
   endtask
   task automatic test_good_frame();
      logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h00};
      int e0 = n_chk + n_len + n_tmo + n_ovr;
      send_gap(8'h00); send_gap(8'h79); send_gap(8'h7A); send_gap(8'h03);
      send_gap(8'h11); send_gap(8'h22); send_gap(8'h33);
      total++; if (bus.o_frame_valid !== 1'b0) begin bad++; $display("FAIL good_valid_early got=%b exp=0", bus.o_frame_valid); end
      send(8'h97);
      total++; if (bus.o_frame_valid !== 1'b1) begin bad++; $display("FAIL good_valid got=%b exp=1", bus.o_frame_valid); end
      total++; if (bus.o_frame_len !== 5'd3) begin bad++; $display("FAIL good_len got=%0d exp=3", bus.o_frame_len); end
      for (int i = 0; i < 4; i++) begin
         read(4'(i));
         total++; if (bus.o_rd_data !== exp[i]) begin bad++; $display("FAIL good_read[%0d] got=%h exp=%h", i, bus.o_rd_data, exp[i]); end
      end
      idle(1);
      total++; if (n_chk + n_len + n_tmo + n_ovr !== e0) begin bad++; $display("FAIL good_no_errors got=%0d exp=%0d", n_chk + n_len + n_tmo + n_ovr, e0); end
      do_ack();
      total++; if (bus.o_frame_valid !== 1'b0) begin bad++; $display("FAIL good_ack got=%b exp=0", bus.o_frame_valid); end
   endtask
   task automatic test_bad_chksum();
      int c = n_chk;
      send_gap(8'h7A); send_gap(8'h03); send_gap(8'h11); send_gap(8'h22); send_gap(8'h33);
      send(8'h98);
      total++; if (bus.o_err_chksum !== 1'b1) begin bad++; $display("FAIL chk_strobe got=%b exp=1", bus.o_err_chksum); end
      total++; if (bus.o_frame_valid !== 1'b0) begin bad++; $display("FAIL chk_valid got=%b exp=0", bus.o_frame_valid); end
      idle(2);
      total++; if (n_chk !== c + 1) begin bad++; $display("FAIL chk_count got=%0d exp=%0d", n_chk, c + 1); end
      send_gap(8'h7A); send_gap(8'h01); send_gap(8'h55);
      send(8'hAA);
      total++; if (bus.o_frame_valid !== 1'b1) begin bad++; $display("FAIL chk_next_valid got=%b exp=1", bus.o_frame_valid); end
      read(4'd0);
      total++; if (bus.o_rd_data !== 8'h55) begin bad++; $display("FAIL chk_next_read got=%h exp=55", bus.o_rd_data); end
      do_ack();
   endtask
   task automatic test_len_err();
      int c = n_len;
      send_gap(8'h7A); send(8'h00);
      idle(2);
      total++; if (n_len !== c + 1) begin bad++; $display("FAIL len_zero got=%0d exp=%0d", n_len, c + 1); end
      send_gap(8'h7A); send(8'h11);
      idle(2);
      total++; if (n_len !== c + 2) begin bad++; $display("FAIL len_big got=%0d exp=%0d", n_len, c + 2); end
      total++; if (bus.o_frame_valid !== 1'b0) begin bad++; $display("FAIL len_valid got=%b exp=0", bus.o_frame_valid); end
   endtask
   task automatic test_back_to_back();
      int e0 = n_chk + n_len;
      send(8'h7A); send(8'h10);
      for (int i = 0; i < 16; i++) send(8'h70 + 8'(i));
      send(8'h78);
      total++; if (bus.o_frame_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b exp=1", bus.o_frame_valid); end
      total++; if (bus.o_frame_len !== 5'd16) begin bad++; $display("FAIL b2b_len got=%0d exp=16", bus.o_frame_len); end
      read(4'd0);
      total++; if (bus.o_rd_data !== 8'h70) begin bad++; $display("FAIL b2b_read0 got=%h exp=70", bus.o_rd_data); end
      read(4'd10);
      total++; if (bus.o_rd_data !== 8'h7A) begin bad++; $display("FAIL b2b_read10 got=%h exp=7a", bus.o_rd_data); end
      read(4'd15);
      total++; if (bus.o_rd_data !== 8'h7F) begin bad++; $display("FAIL b2b_read15 got=%h exp=7f", bus.o_rd_data); end
      total++; if (n_chk + n_len !== e0) begin bad++; $display("FAIL b2b_errors got=%0d exp=%0d", n_chk + n_len, e0); end
      do_ack();
   endtask
   task automatic test_timeout();
      int c = n_tmo;
      send_gap(8'h7A); send_gap(8'h02); send(8'h11);
      idle(2000);
      send(8'h22); send(8'hCB);
      total++; if (bus.o_frame_valid !== 1'b1) begin bad++; $display("FAIL tmo_edge_valid got=%b exp=1", bus.o_frame_valid); end
      idle(2);
      total++; if (n_tmo !== c) begin bad++; $display("FAIL tmo_edge_count got=%0d exp=%0d", n_tmo, c); end
      do_ack();
      send_gap(8'h7A); send_gap(8'h02); send(8'h11);
      idle(2000);
      total++; if (bus.o_err_timeout !== 1'b0) begin bad++; $display("FAIL tmo_early got=%b exp=0", bus.o_err_timeout); end
      idle(1);
      total++; if (bus.o_err_timeout !== 1'b1) begin bad++; $display("FAIL tmo_strobe got=%b exp=1", bus.o_err_timeout); end
      idle(1);
      total++; if (bus.o_err_timeout !== 1'b0) begin bad++; $display("FAIL tmo_width got=%b exp=0", bus.o_err_timeout); end
      idle(1);
      total++; if (n_tmo !== c + 1) begin bad++; $display("FAIL tmo_count got=%0d exp=%0d", n_tmo, c + 1); end
      send_gap(8'h7A); send_gap(8'h01); send_gap(8'h55); send(8'hAA);
      total++; if (bus.o_frame_valid !== 1'b1) begin bad++; $display("FAIL tmo_next_valid got=%b exp=1", bus.o_frame_valid); end
      read(4'd0);
      total++; if (bus.o_rd_data !== 8'h55) begin bad++; $display("FAIL tmo_next_read got=%h exp=55", bus.o_rd_data); end
      do_ack();
   endtask
   task automatic test_overrun();
      int c = n_ovr;
      send_gap(8'h7A); send_gap(8'h01); send_gap(8'h55); send(8'hAA);
      send(8'h7A);
      total++; if (bus.o_overrun !== 1'b1) begin bad++; $display("FAIL ovr_strobe got=%b exp=1", bus.o_overrun); end
      total++; if (bus.o_frame_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b exp=1", bus.o_frame_valid); end
      read(4'd0);
      total++; if (bus.o_rd_data !== 8'h55) begin bad++; $display("FAIL ovr_payload got=%h exp=55", bus.o_rd_data); end
      total++; if (bus.o_frame_len !== 5'd1) begin bad++; $display("FAIL ovr_len got=%0d exp=1", bus.o_frame_len); end
      bus.i_frame_ack = 1'b1; bus.i_rx_valid = 1'b1; bus.i_rx_byte = 8'h7A;
      @(negedge clk);
      bus.i_frame_ack = 1'b0; bus.i_rx_valid = 1'b0; bus.i_rx_byte = 8'h00;
      total++; if (bus.o_frame_valid !== 1'b0) begin bad++; $display("FAIL ovr_ack_valid got=%b exp=0", bus.o_frame_valid); end
      total++; if (bus.o_overrun !== 1'b1) begin bad++; $display("FAIL ovr_ack_strobe got=%b exp=1", bus.o_overrun); end
      send(8'h01); send(8'h55); send(8'hAA);
      total++; if (bus.o_frame_valid !== 1'b0) begin bad++; $display("FAIL ovr_dropped got=%b exp=0", bus.o_frame_valid); end
      idle(1);
      total++; if (n_ovr !== c + 2) begin bad++; $display("FAIL ovr_count got=%0d exp=%0d", n_ovr, c + 2); end
      send_gap(8'h7A); send_gap(8'h01); send_gap(8'h66); send(8'h99);
      do_ack();
      send(8'h7A); send(8'h01); send(8'h44); send(8'hBB);
      total++; if (bus.o_frame_valid !== 1'b1) begin bad++; $display("FAIL ack_next_valid got=%b exp=1", bus.o_frame_valid); end
      read(4'd0);
      total++; if (bus.o_rd_data !== 8'h44) begin bad++; $display("FAIL ack_next_read got=%h exp=44", bus.o_rd_data); end
      do_ack();
   endtask
   task automatic test_reset_mid();
      int e0 = n_chk + n_len + n_tmo + n_ovr;
      send_gap(8'h7A); send_gap(8'h03); send(8'h11);
      bus.i_rd_addr = 4'd0;
      rst_n = 1'b0;
      #1;
      total++; if ({bus.o_frame_valid, bus.o_frame_len, bus.o_rd_data} !== 14'd0) begin
         bad++; $display("FAIL rstmid_outputs got=%h exp=0", {bus.o_frame_valid, bus.o_frame_len, bus.o_rd_data}); end
      idle(2);
      total++; if ({bus.o_err_chksum, bus.o_err_len, bus.o_err_timeout, bus.o_overrun} !== 4'b0000) begin
         bad++; $display("FAIL rstmid_strobes got=%b exp=0000", {bus.o_err_chksum, bus.o_err_len, bus.o_err_timeout, bus.o_overrun}); end
      rst_n = 1'b1;
      idle(2);
      send_gap(8'h22); send_gap(8'h33); send_gap(8'h97);
      total++; if (bus.o_frame_valid !== 1'b0) begin bad++; $display("FAIL rstmid_discard got=%b exp=0", bus.o_frame_valid); end
      send_gap(8'h7A); send_gap(8'h03); send_gap(8'h11); send_gap(8'h22); send_gap(8'h33); send(8'h97);
      total++; if (bus.o_frame_valid !== 1'b1) begin bad++; $display("FAIL rstmid_valid got=%b exp=1", bus.o_frame_valid); end
      total++; if (bus.o_frame_len !== 5'd3) begin bad++; $display("FAIL rstmid_len got=%0d exp=3", bus.o_frame_len); end
      read(4'd2);
      total++; if (bus.o_rd_data !== 8'h33) begin bad++; $display("FAIL rstmid_read2 got=%h exp=33", bus.o_rd_data); end
      total++; if (n_chk + n_len + n_tmo + n_ovr !== e0) begin bad++; $display("FAIL rstmid_errors got=%0d exp=%0d", n_chk + n_len + n_tmo + n_ovr, e0); end
      do_ack();
   endtask
   initial begin
      test_reset();
      test_good_frame();
      test_bad_chksum();
      test_len_err();
      test_back_to_back();
      test_timeout();
      test_overrun();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
